// File: rtl/mask_line_buffer.sv
// Multi-channel binary line buffer: keeps the mask bits of the last NUM_TAPS
// completed lines and presents a gated vertical column at the current column.
module mask_line_buffer #(
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_W     = 10,
    parameter int NUM_TAPS   = 3,
    parameter int CHANNELS   = 1,
    localparam int LF_W      = $clog2(NUM_TAPS + 1)
) (
    input  logic                         iVgaClk,
    input  logic                         iReset,
    input  logic                         iVgaHRequest,
    input  logic                         iFrameStart,
    input  logic [ADDR_W-1:0]            iHIndex,
    input  logic [CHANNELS-1:0]          iMaskBits,
    output logic [NUM_TAPS*CHANNELS-1:0] oTaps,
    output logic                         oTapValid,
    output logic [ADDR_W-1:0]            oTapHIndex,
    output logic [LF_W-1:0]              oLinesFilled
);

    localparam int NUM_BUFS = NUM_TAPS + 1;
    localparam int PTR_W    = $clog2(NUM_BUFS);
    localparam int RAM_AW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [PTR_W-1:0] LAST_BUF    = PTR_W'(NUM_TAPS);
    localparam logic [LF_W-1:0]  MAX_LINES   = LF_W'(NUM_TAPS);
    localparam logic [ADDR_W:0]  WIDTH_LIMIT = (ADDR_W + 1)'(LINE_WIDTH);

    logic                         in_range;
    logic                         wr_en;
    logic                         line_end;
    logic [RAM_AW-1:0]            ram_addr;
    logic [PTR_W-1:0]             wr;
    logic                         hreq_d;
    logic [NUM_BUFS*CHANNELS-1:0] rd_all;
    logic [PTR_W-1:0]             wr_d;
    logic [LF_W-1:0]              lines_d;
    logic                         valid_d;
    logic [ADDR_W-1:0]            hidx_d;
    logic [NUM_TAPS*CHANNELS-1:0] tap_next;
    int                           sel;

    assign in_range = {1'b0, iHIndex} < WIDTH_LIMIT;
    assign wr_en    = iVgaHRequest & in_range;
    assign line_end = hreq_d & ~iVgaHRequest;
    // Out-of-range columns read address 0; their output is flagged invalid.
    assign ram_addr = in_range ? iHIndex[RAM_AW-1:0] : '0;

    // Frame start overrides an end of line landing in the same cycle.
    always_ff @(posedge iVgaClk or posedge iReset) begin
        if (iReset) begin
            wr           <= '0;
            hreq_d       <= 1'b0;
            oLinesFilled <= '0;
        end else begin
            hreq_d <= iVgaHRequest;
            if (iFrameStart) begin
                wr           <= '0;
                oLinesFilled <= '0;
            end else if (line_end) begin
                wr <= (wr == LAST_BUF) ? '0 : wr + 1'b1;
                if (oLinesFilled != MAX_LINES) begin
                    oLinesFilled <= oLinesFilled + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BUFS; b++) begin : g_buf
        logic [CHANNELS-1:0] mem [LINE_WIDTH];
        logic [CHANNELS-1:0] rd;

        always_ff @(posedge iVgaClk) begin
            if (wr_en && (wr == PTR_W'(b))) begin
                mem[ram_addr] <= iMaskBits;
            end
        end

        always_ff @(posedge iVgaClk or posedge iReset) begin
            if (iReset) begin
                rd <= '0;
            end else begin
                rd <= mem[ram_addr];
            end
        end

        assign rd_all[b*CHANNELS +: CHANNELS] = rd;
    end

    always_ff @(posedge iVgaClk or posedge iReset) begin
        if (iReset) begin
            wr_d    <= '0;
            lines_d <= '0;
            valid_d <= 1'b0;
            hidx_d  <= '0;
        end else begin
            wr_d    <= wr;
            lines_d <= oLinesFilled;
            valid_d <= wr_en;
            hidx_d  <= iHIndex;
        end
    end

    // Tap k maps to buffer (wr_d + k + 1) mod NUM_BUFS, i.e. wr_d - NUM_TAPS + k.
    always_comb begin
        tap_next = '0;
        sel      = 0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sel = int'(wr_d) + k + 1;
            if (sel >= NUM_BUFS) begin
                sel = sel - NUM_BUFS;
            end
            if (int'(lines_d) >= NUM_TAPS - k) begin
                tap_next[k*CHANNELS +: CHANNELS] = rd_all[sel*CHANNELS +: CHANNELS];
            end
        end
    end

    always_ff @(posedge iVgaClk or posedge iReset) begin
        if (iReset) begin
            oTaps      <= '0;
            oTapValid  <= 1'b0;
            oTapHIndex <= '0;
        end else begin
            oTaps      <= tap_next;
            oTapValid  <= valid_d;
            oTapHIndex <= hidx_d;
        end
    end

endmodule

// File: tb/tb_mask_line_buffer.sv
// Bench for mask_line_buffer: random line traffic compared against a model
// that keeps the completed lines of the current frame as a queue.
module tb_mask_line_buffer;

    localparam int LW = 8;
    localparam int AW = 4;
    localparam int NT = 3;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          hreq;
    logic          fs;
    logic [AW-1:0] hidx;
    logic [CH-1:0] bits;
    logic [NT*CH-1:0] taps;
    logic          tap_valid;
    logic [AW-1:0] tap_hidx;
    logic [1:0]    lines;

    mask_line_buffer #(
        .LINE_WIDTH(LW),
        .ADDR_W    (AW),
        .NUM_TAPS  (NT),
        .CHANNELS  (CH)
    ) dut (
        .iVgaClk     (clk),
        .iReset      (rst),
        .iVgaHRequest(hreq),
        .iFrameStart (fs),
        .iHIndex     (hidx),
        .iMaskBits   (bits),
        .oTaps       (taps),
        .oTapValid   (tap_valid),
        .oTapHIndex  (tap_hidx),
        .oLinesFilled(lines)
    );

    always #5 clk = ~clk;

    // exp_q entry: {check_taps, valid, hidx[3:0], taps[5:0]}
    logic [11:0] exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] cur_line;
    int          m_lines;
    logic        m_prev_hreq;
    int          checks;
    int          errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pixel-clock cycle: compare the output due now, predict this cycle's
    // output from the model, update the model, drive the DUT, advance.
    task automatic step(input logic h, input logic [AW-1:0] idx, input logic [CH-1:0] b,
                        input logic f);
        logic [11:0] e;
        logic [5:0]  t;
        logic [15:0] ln;
        int          ii;
        ii = int'(idx);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_eq("tap_valid", 32'(tap_valid), 32'(e[10]));
            check_eq("tap_hidx", 32'(tap_hidx), 32'(e[9:6]));
            if (e[11]) check_eq("taps", 32'(taps), 32'(e[5:0]));
        end
        check_eq("lines_filled", 32'(lines), m_lines);
        t = '0;
        if (ii < LW) begin
            for (int k = 0; k < NT; k++) begin
                if (m_lines >= NT - k) begin
                    ln = hist[m_lines - NT + k];
                    t[k*CH +: CH] = ln[ii*CH +: CH];
                end
            end
        end
        exp_q.push_back({(ii < LW), (h && (ii < LW)), idx, t});
        if (h && (ii < LW)) cur_line[ii*CH +: CH] = b;
        if (f) begin
            hist.delete();
            m_lines = 0;
        end else if (m_prev_hreq && !h) begin
            hist.push_back(cur_line);
            if (hist.size() > NT) void'(hist.pop_front());
            if (m_lines < NT) m_lines++;
        end
        m_prev_hreq = h;
        hreq = h;
        hidx = idx;
        bits = b;
        fs   = f;
        @(posedge clk);
        #1;
    endtask

    // mode 0: every pixel carries line_no[1:0]; mode 1: random pixels.
    task automatic run_line(input int mode, input int line_no, input bit oor, input bit fs_end);
        logic [CH-1:0] b;
        logic [31:0]   ln_v;
        ln_v = line_no;
        for (int c = 0; c < LW; c++) begin
            b = (mode == 0) ? ln_v[1:0] : 2'($urandom);
            step(1'b1, 4'(c), b, 1'b0);
            if (oor && c == 3) step(1'b1, 4'd9, 2'($urandom), 1'b0);
        end
        step(1'b0, 4'($urandom_range(0, LW - 1)), 2'($urandom), fs_end);
        step(1'b0, 4'($urandom_range(0, LW - 1)), 2'($urandom), 1'b0);
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        m_lines     = 0;
        m_prev_hreq = 1'b0;
        cur_line    = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        hreq = 1'b0;
        fs   = 1'b0;
        hidx = '0;
        bits = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_taps", 32'(taps), 0);
        check_eq("reset_valid", 32'(tap_valid), 0);
        check_eq("reset_hidx", 32'(tap_hidx), 0);
        check_eq("reset_lines", 32'(lines), 0);
        rst = 1'b0;

        step(1'b0, 4'd0, 2'd0, 1'b1);
        for (int l = 0; l < 6; l++) run_line(0, l, 1'b0, 1'b0);
        for (int l = 6; l < 16; l++) run_line(1, l, (l % 3) == 0, 1'b0);
        run_line(1, 16, 1'b0, 1'b1);
        run_line(1, 17, 1'b1, 1'b0);
        run_line(1, 18, 1'b0, 1'b0);

        for (int c = 0; c < 4; c++) step(1'b1, 4'(c), 2'($urandom), 1'b0);
        rst  = 1'b1;
        hreq = 1'b0;
        #1;
        check_eq("midline_reset_taps", 32'(taps), 0);
        check_eq("midline_reset_valid", 32'(tap_valid), 0);
        check_eq("midline_reset_lines", 32'(lines), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int l = 0; l < 5; l++) run_line(1, 20 + l, 1'b0, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
